// File: rtl/cast_sum_sink.sv
// Stream sink that checks each word against the all-ones constant and
// reports per-frame match/mismatch counts, a wrapping sum and pass/fail.
//
// state  | meaning
// IDLE   | waiting for the first word of a frame
// RECV   | inside a frame, accepting words until in_last
// REPORT | frame complete, results frozen until clear
module cast_sum_sink #(
  parameter int P     = 1,
  parameter int CNT_W = 8,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [P+1:0]     in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             clear,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [ACC_W-1:0] acc,
  output logic             done,
  output logic             pass
);

  localparam int W = P + 2;
  localparam logic [W-1:0]     EXP     = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;

  state_t           state;
  logic             xfer;
  logic             is_match;
  logic [CNT_W-1:0] match_nxt;
  logic [CNT_W-1:0] mismatch_nxt;
  logic [ACC_W-1:0] acc_nxt;

  assign in_ready = (state != REPORT);
  assign xfer     = in_valid && in_ready;
  assign is_match = (in_data == EXP);
  assign acc_nxt  = acc + ACC_W'(in_data);

  // Saturating counters: only the counter selected by this word moves.
  always_comb begin
    match_nxt    = match_cnt;
    mismatch_nxt = mismatch_cnt;
    if (is_match) begin
      if (match_cnt != CNT_MAX) match_nxt = match_cnt + CNT_W'(1);
    end else begin
      if (mismatch_cnt != CNT_MAX) mismatch_nxt = mismatch_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      acc          <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      case (state)
        IDLE, RECV: begin
          if (xfer) begin
            match_cnt    <= match_nxt;
            mismatch_cnt <= mismatch_nxt;
            acc          <= acc_nxt;
            if (in_last) begin
              // Verdict uses the counts that already include the last word.
              state <= REPORT;
              done  <= 1'b1;
              pass  <= (mismatch_nxt == '0) && (match_nxt != '0);
            end else begin
              state <= RECV;
            end
          end
        end
        REPORT: begin
          if (clear) begin
            state        <= IDLE;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            acc          <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cast_sum_sink.sv
// Bench for cast_sum_sink: three instances (P=1, P=3, narrow counters) share
// one stimulus stream; a scoreboard queue is checked whenever done rises.
module tb_cast_sum_sink;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_last;
  logic       clear;

  logic       rdy0, rdy1, rdy2;
  logic [7:0] mc0, mm0, ac0, mc1, mm1, ac1;
  logic [3:0] mc2, mm2, ac2;
  logic       dn0, dn1, dn2, ps0, ps1, ps2;

  always #5 clk = ~clk;

  cast_sum_sink #(.P(1), .CNT_W(8), .ACC_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[2:0]),
    .in_last(in_last), .in_ready(rdy0), .clear(clear), .match_cnt(mc0),
    .mismatch_cnt(mm0), .acc(ac0), .done(dn0), .pass(ps0));

  cast_sum_sink #(.P(3), .CNT_W(8), .ACC_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy1), .clear(clear), .match_cnt(mc1),
    .mismatch_cnt(mm1), .acc(ac1), .done(dn1), .pass(ps1));

  cast_sum_sink #(.P(1), .CNT_W(4), .ACC_W(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[2:0]),
    .in_last(in_last), .in_ready(rdy2), .clear(clear), .match_cnt(mc2),
    .mismatch_cnt(mm2), .acc(ac2), .done(dn2), .pass(ps2));

  int mc[3], mm[3], ac[3], dn[3], ps[3], rd[3];
  always_comb begin
    mc[0] = int'(mc0); mm[0] = int'(mm0); ac[0] = int'(ac0);
    mc[1] = int'(mc1); mm[1] = int'(mm1); ac[1] = int'(ac1);
    mc[2] = int'(mc2); mm[2] = int'(mm2); ac[2] = int'(ac2);
    dn[0] = int'(dn0); dn[1] = int'(dn1); dn[2] = int'(dn2);
    ps[0] = int'(ps0); ps[1] = int'(ps1); ps[2] = int'(ps2);
    rd[0] = int'(rdy0); rd[1] = int'(rdy1); rd[2] = int'(rdy2);
  end

  // Instance configuration for the reference model.
  int PP[3] = '{1, 3, 1};
  int CW[3] = '{8, 8, 4};
  int AW[3] = '{8, 8, 4};

  typedef struct packed {
    logic [2:0][31:0] m;
    logic [2:0][31:0] mm;
    logic [2:0][31:0] a;
    logic [2:0]       p;
  } exp_t;

  exp_t sb[$];
  int   raw_m[3], raw_mm[3], raw_s[3];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      raw_m[i] = 0; raw_mm[i] = 0; raw_s[i] = 0;
    end
  endfunction

  function automatic void model_word(input logic [4:0] d);
    for (int i = 0; i < 3; i++) begin
      int mask = (1 << (PP[i] + 2)) - 1;
      int v = int'(d) & mask;
      if (v == mask) raw_m[i]++;
      else raw_mm[i]++;
      raw_s[i] += v;
    end
  endfunction

  function automatic void model_frame_end();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      int sat = (1 << CW[i]) - 1;
      e.m[i]  = (raw_m[i] > sat) ? sat : raw_m[i];
      e.mm[i] = (raw_mm[i] > sat) ? sat : raw_mm[i];
      e.a[i]  = raw_s[i] % (1 << AW[i]);
      e.p[i]  = (raw_mm[i] == 0) && (raw_m[i] > 0);
    end
    sb.push_back(e);
    model_reset();
  endfunction

  // Monitor: pops one expected report per rising edge of done.
  initial begin
    int prev = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && dn[0] == 1 && prev == 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          for (int i = 0; i < 3; i++) begin
            chk($sformatf("sb_match_u%0d", i), mc[i], int'(e.m[i]));
            chk($sformatf("sb_mismatch_u%0d", i), mm[i], int'(e.mm[i]));
            chk($sformatf("sb_acc_u%0d", i), ac[i], int'(e.a[i]));
            chk($sformatf("sb_pass_u%0d", i), ps[i], int'(e.p[i]));
            chk($sformatf("sb_done_u%0d", i), dn[i], 1);
            chk($sformatf("sb_ready_u%0d", i), rd[i], 0);
          end
        end
      end
      prev = dn[0];
    end
  end

  // All tasks start and end at posedge+1.
  task automatic check_cleared(input string tag);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_match_u%0d", tag, i), mc[i], 0);
      chk($sformatf("%s_mismatch_u%0d", tag, i), mm[i], 0);
      chk($sformatf("%s_acc_u%0d", tag, i), ac[i], 0);
      chk($sformatf("%s_done_u%0d", tag, i), dn[i], 0);
      chk($sformatf("%s_pass_u%0d", tag, i), ps[i], 0);
      chk($sformatf("%s_ready_u%0d", tag, i), rd[i], 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_data  = 5'($urandom);
      in_last  = 1'($urandom);
      clear    = 1'($urandom);
      @(posedge clk); #1;
    end
    clear = 1'b0;
  endtask

  task automatic send(input logic [4:0] d, input bit last);
    int budget = 0;
    int accepted = 0;
    clear    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (accepted == 0 && budget < 50) begin
      @(negedge clk);
      accepted = rd[0];
      @(posedge clk); #1;
      budget++;
    end
    if (accepted == 0) chk("accept_timeout", 0, 1);
    else model_word(d);
    in_valid = 1'b0;
    in_data  = 5'($urandom);
    in_last  = 1'($urandom);
    if (last && accepted != 0) begin
      model_frame_end();
      @(negedge clk);
      chk("done_latency", dn[0], 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_cleared("after_clear");
  endtask

  task automatic pulse_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 5'h1F;
    in_last  = 1'b1;
    clear    = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; clear = 1'b0;
    model_reset();
  endtask

  function automatic logic [4:0] pick();
    case ($urandom_range(0, 3))
      0, 3:    return 5'h1F;
      1:       return 5'h07;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then idle cycles with junk data must change nothing.
    check_cleared("reset");
    for (int k = 0; k < 5; k++) check_cleared("idle");

    // Happy frame on P=1.
    send(5'h07, 0); send(5'h07, 0); send(5'h07, 1);
    chk("happy_match", mc[0], 3);
    chk("happy_mismatch", mm[0], 0);
    chk("happy_acc", ac[0], 21);
    chk("happy_pass", ps[0], 1);
    chk("happy_ready", rd[0], 0);
    do_clear();

    // Mismatch frame, then a word offered during REPORT is refused.
    send(5'h07, 0); send(5'h05, 1);
    in_valid = 1'b1; in_data = 5'h07; in_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_match", mc[0], 1);
      chk("bp_mismatch", mm[0], 1);
      chk("bp_acc", ac[0], 12);
      chk("bp_pass", ps[0], 0);
      chk("bp_done", dn[0], 1);
      @(posedge clk); #1;
    end
    do_clear();

    // Single-word frame, all-ones for P=3.
    send(5'h1F, 1);
    chk("single_match_p3", mc[1], 1);
    chk("single_acc_p3", ac[1], 31);
    chk("single_pass_p3", ps[1], 1);
    do_clear();

    // Saturation of the 4-bit counter and wrap of the 4-bit accumulator.
    for (int k = 0; k < 20; k++) send(5'h07, k == 19);
    chk("sat_match_u2", mc[2], 15);
    chk("sat_acc_u2", ac[2], 12);
    chk("sat_pass_u2", ps[2], 1);
    chk("sat_match_u0", mc[0], 20);
    chk("sat_acc_u0", ac[0], 140);
    do_clear();

    // Reset mid-frame discards the partial frame.
    send(5'h07, 0); send(5'h07, 0);
    pulse_reset();
    check_cleared("midrst");
    send(5'h07, 1);
    chk("midrst_frame_match", mc[0], 1);
    do_clear();

    // Randomized frames with idle gaps and stray clear pulses inside frames.
    for (int f = 0; f < 12; f++) begin
      int len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        gap($urandom_range(0, 2));
        send(pick(), j == len - 1);
      end
      do_clear();
    end

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
